acondicionador_botones: RTL and testbench
=========================================

// Module: acondicionador_botones
// PURPOSE
//  Upstream input stage for the tic-tac-toe controller: conditions the five raw push-buttons (up, down, left, right, select).
//  Each button path has a 2-FF synchroniser, a debounce counter and a rising-edge detector.
//  Outputs are single-cycle pulses that directly drive the boton_arriba/abajo/izq/der/elige inputs of the square selector.
//  One press yields exactly one pulse, regardless of hold time or contact bounce.
// PARAMETERS
//  DB_CYCLES  4                        consecutive synchronised cycles a new level must hold before it is accepted (>=2; board build 500000)
//  CNT_W      $clog2(DB_CYCLES+1)      debounce counter width (localparam, derived)
// PORTS
//  clk             in   1  system clock, all logic on rising edge
//  reset           in   1  asynchronous, active-high; clears all state
//  pb_arriba       in   1  raw button, active-high, asynchronous to clk
//  pb_abajo        in   1  raw button, active-high
//  pb_izq          in   1  raw button, active-high
//  pb_der          in   1  raw button, active-high
//  pb_elige        in   1  raw button, active-high
//  habilita        in   1  1 = pulses allowed; 0 = pulses suppressed (debounce keeps running)
//  boton_arriba    out  1  one-cycle press pulse
//  boton_abajo     out  1  one-cycle press pulse
//  boton_izq       out  1  one-cycle press pulse
//  boton_der       out  1  one-cycle press pulse
//  boton_elige     out  1  one-cycle press pulse
//  estable         out  5  debounced levels {elige,der,izq,abajo,arriba}
// BEHAVIOUR
//  - Reset (async assert, sync release by the system): sync FFs=0, counters=0, estable=5'b0, all pulse outputs=0.
//  - Per button, identical and independent:
//    s1<=pb; s2<=s1.
//    If s2==estable[i]: cnt<=0.
//    Else if cnt==DB_CYCLES-1: estable[i]<=s2, cnt<=0.
//    Else: cnt<=cnt+1.
//  - Pulse register: pulse[i] <= (estable_next[i] & ~estable[i]) & habilita.
//    It is high for exactly the one cycle following the edge at which estable[i] rises.
//  - Latency: raw rise set up before edge 0 -> s2=1 after edge 1 -> estable and pulse high after edge DB_CYCLES+1.
//    Pulse drops after edge DB_CYCLES+2.
//  - Glitch / bounce: any s2 sample equal to estable restarts the count.
//    A level held for fewer than DB_CYCLES consecutive s2 samples is never accepted.
//  - Release (estable 1->0) is debounced identically and produces no pulse.
//  - Hold: no further pulses until estable returns to 0 and rises again (no auto-repeat).
//  - habilita=0 at the rising edge of estable: that press is discarded, not queued.
//    Raising habilita later while still held gives no pulse.
//  - Simultaneous presses: each button pulses independently.
//    Several outputs may be high in the same cycle; arbitration belongs to the consumer.
//  - Reset mid-debounce: count lost.
//    A button still held after reset release is treated as a new press and pulses DB_CYCLES+2 edges after release (if habilita=1).
//  - Counter never exceeds DB_CYCLES-1; no wrap-around possible.
// TESTING (DB_CYCLES=4, habilita=1 unless stated)
//  1. Reset, pb_elige 0->1 held 20 cycles -> boton_elige high exactly 1 cycle, at edge 5 after the input change; estable[4]=1.
//  2. pb_der bounce 1,0,1,1,0 then steady 1 -> single boton_der pulse 5 edges after the last 0->1; no earlier pulse.
//  3. pb_izq 3-cycle glitch -> no pulse, estable[2] stays 0; release of a held button -> no pulse.
//  4. habilita=0 during the pb_arriba press, then 1 while held -> no boton_arriba pulse; next press pulses normally.
//  5. pb_arriba and pb_abajo rise on the same cycle -> both pulses high on the same cycle.
//  6. Assert reset at debounce count 2 with pb_abajo held -> all outputs 0 at once; pulse 5 edges after reset release.

Source files
------------

// File: rtl/acondicionador_botones.sv
// Button conditioner: sync, debounce and press-pulse for five raw push-buttons.
// Ports: clk, reset (async high), pb_* raw inputs, habilita, boton_* pulses, estable[4:0].
module acondicionador_botones #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pb_arriba,
  input  logic       pb_abajo,
  input  logic       pb_izq,
  input  logic       pb_der,
  input  logic       pb_elige,
  input  logic       habilita,
  output logic       boton_arriba,
  output logic       boton_abajo,
  output logic       boton_izq,
  output logic       boton_der,
  output logic       boton_elige,
  output logic [4:0] estable
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0]       pb;
  logic [4:0]       s1;
  logic [4:0]       s2;
  logic [4:0]       estable_q;
  logic [4:0]       estable_next;
  logic [4:0]       pulse_q;
  logic [CNT_W-1:0] cnt_q    [5];
  logic [CNT_W-1:0] cnt_next [5];

  // Bit order matches estable: {elige,der,izq,abajo,arriba}
  assign pb = {pb_elige, pb_der, pb_izq, pb_abajo, pb_arriba};

  // Any sample agreeing with the accepted level restarts the count,
  // so only DB_CYCLES consecutive disagreeing samples flip the level.
  always_comb begin
    estable_next = estable_q;
    for (int i = 0; i < 5; i++) begin
      cnt_next[i] = cnt_q[i];
      if (s2[i] == estable_q[i]) begin
        cnt_next[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        estable_next[i] = s2[i];
        cnt_next[i]     = '0;
      end else begin
        cnt_next[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      estable_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1        <= pb;
      s2        <= s1;
      estable_q <= estable_next;
      // Rising edge of the accepted level only; a press
      // seen while disabled is dropped, never replayed.
      pulse_q   <= estable_next & ~estable_q & {5{habilita}};
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  assign estable      = estable_q;
  assign boton_arriba = pulse_q[0];
  assign boton_abajo  = pulse_q[1];
  assign boton_izq    = pulse_q[2];
  assign boton_der    = pulse_q[3];
  assign boton_elige  = pulse_q[4];

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones with DB_CYCLES=4.
// Stimulus pushes expected pulses; a monitor pops on every pulse.
module tb_acondicionador_botones;

  logic       clk = 1'b0;
  logic       reset;
  logic       pb_arriba, pb_abajo, pb_izq, pb_der, pb_elige;
  logic       habilita;
  logic       boton_arriba, boton_abajo, boton_izq;
  logic       boton_der, boton_elige;
  logic [4:0] estable;

  acondicionador_botones #(.DB_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pb_arriba    (pb_arriba),
    .pb_abajo     (pb_abajo),
    .pb_izq       (pb_izq),
    .pb_der       (pb_der),
    .pb_elige     (pb_elige),
    .habilita     (habilita),
    .boton_arriba (boton_arriba),
    .boton_abajo  (boton_abajo),
    .boton_izq    (boton_izq),
    .boton_der    (boton_der),
    .boton_elige  (boton_elige),
    .estable      (estable)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc++;

  function automatic logic [4:0] pulses();
    return {boton_elige, boton_der, boton_izq,
            boton_abajo, boton_arriba};
  endfunction

  // Input set at negedge n is sampled at edge n+1 (edge 0);
  // the pulse is visible after edge 0+5, i.e. cyc == n+6.
  function automatic void expect_pulse(int n, logic [4:0] m);
    exp_t e;
    e.cyc  = n + 6;
    e.mask = m;
    sb.push_back(e);
  endfunction

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string name, logic [4:0] act,
                     logic [4:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%b required=%b cyc=%0d",
               name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle with a pulse consumes one expectation.
  always @(negedge clk) begin
    logic [4:0] p;
    exp_t       e;
    p = pulses();
    if (reset === 1'b0 && p != 5'b0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got=%b cyc=%0d required=none",
                 p, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.mask != p) begin
          bad++;
          $display("FAIL pulse got=%b@%0d required=%b@%0d",
                   p, cyc, e.mask, e.cyc);
        end
      end
    end
  end

  int seq [5] = '{1, 0, 1, 1, 0};
  int n;

  initial begin
    reset     = 1'b1;
    pb_arriba = 1'b0;
    pb_abajo  = 1'b0;
    pb_izq    = 1'b0;
    pb_der    = 1'b0;
    pb_elige  = 1'b0;
    habilita  = 1'b1;
    wait_cyc(3);
    chk("reset_estable", estable, 5'b00000);
    chk("reset_pulses", pulses(), 5'b00000);
    reset = 1'b0;
    wait_cyc(2);

    // 1: clean press held 20 cycles, then release
    n = cyc;
    pb_elige = 1'b1;
    expect_pulse(n, 5'b10000);
    wait_cyc(20);
    chk("t1_estable_held", estable, 5'b10000);
    pb_elige = 1'b0;
    wait_cyc(10);
    chk("t1_estable_rel", estable, 5'b00000);

    // 2: bounce then steady
    for (int i = 0; i < 5; i++) begin
      pb_der = seq[i][0];
      wait_cyc(1);
    end
    chk("t2_no_early", estable, 5'b00000);
    n = cyc;
    pb_der = 1'b1;
    expect_pulse(n, 5'b01000);
    wait_cyc(15);
    chk("t2_estable_held", estable, 5'b01000);
    pb_der = 1'b0;
    wait_cyc(10);
    chk("t2_estable_rel", estable, 5'b00000);

    // 3: 3-cycle glitch rejected; 4-cycle press accepted
    pb_izq = 1'b1;
    wait_cyc(3);
    pb_izq = 1'b0;
    wait_cyc(10);
    chk("t3_glitch", estable, 5'b00000);
    n = cyc;
    pb_izq = 1'b1;
    expect_pulse(n, 5'b00100);
    wait_cyc(4);
    pb_izq = 1'b0;
    wait_cyc(4);
    chk("t3_four_ok", estable, 5'b00100);
    wait_cyc(10);
    chk("t3_released", estable, 5'b00000);

    // 4: press while disabled is discarded
    habilita = 1'b0;
    pb_arriba = 1'b1;
    wait_cyc(10);
    chk("t4_estable_dis", estable, 5'b00001);
    habilita = 1'b1;
    wait_cyc(5);
    pb_arriba = 1'b0;
    wait_cyc(10);
    chk("t4_released", estable, 5'b00000);
    n = cyc;
    pb_arriba = 1'b1;
    expect_pulse(n, 5'b00001);
    wait_cyc(10);
    pb_arriba = 1'b0;
    wait_cyc(10);

    // 5: simultaneous presses
    n = cyc;
    pb_arriba = 1'b1;
    pb_abajo  = 1'b1;
    expect_pulse(n, 5'b00011);
    wait_cyc(10);
    chk("t5_estable", estable, 5'b00011);
    pb_arriba = 1'b0;
    pb_abajo  = 1'b0;
    wait_cyc(10);
    chk("t5_released", estable, 5'b00000);

    // 6: reset at debounce count 2, button still held
    pb_abajo = 1'b1;
    wait_cyc(4);
    reset = 1'b1;
    #1;
    chk("t6_rst_pulses", pulses(), 5'b00000);
    chk("t6_rst_estable", estable, 5'b00000);
    wait_cyc(2);
    n = cyc;
    reset = 1'b0;
    expect_pulse(n, 5'b00010);
    wait_cyc(10);
    chk("t6_estable", estable, 5'b00010);
    pb_abajo = 1'b0;
    wait_cyc(10);
    chk("t6_released", estable, 5'b00000);

    wait_cyc(5);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses got=%0d_pending required=0",
               sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
